gg_serial_ctrl: RTL and testbench

//  Game Gear EXT-port serial engine behind I/O ports $03 (TXD), $04 (RXD) and $05 (SCTRL).

---
 rtl/gg_serial_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_gg_serial_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gg_serial_ctrl.sv
// gg_serial_ctrl: Game Gear EXT-port serial engine (TXD $03, RXD $04, SCTRL $05).
// Bus registers, TX/RX shift FSMs, baud timebase, status flags and serial NMI.
module gg_serial_ctrl #(
    parameter int CLK_FREQ = 21477270
) (
    input  logic       clk,
    input  logic       RESET_n,
    input  logic       WR_n,
    input  logic       RD_n,
    input  logic [7:0] A,
    input  logic [7:0] D_in,
    output logic [7:0] D_out,
    output logic       txd,
    input  logic       rxd,
    output logic       nmi_n
);

    localparam int R0   = CLK_FREQ / 4800;
    localparam int R1   = CLK_FREQ / 2400;
    localparam int R2   = CLK_FREQ / 1200;
    localparam int R3   = CLK_FREQ / 300;
    localparam int PER0 = (R0 < 2) ? 2 : R0;
    localparam int PER1 = (R1 < 2) ? 2 : R1;
    localparam int PER2 = (R2 < 2) ? 2 : R2;
    localparam int PER3 = (R3 < 2) ? 2 : R3;
    localparam int CW   = $clog2(PER3 + 1);

    typedef logic [CW-1:0] cnt_t;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_t;

    function automatic cnt_t period(input logic [1:0] b);
        case (b)
            2'b00:   return cnt_t'(PER0);
            2'b01:   return cnt_t'(PER1);
            2'b10:   return cnt_t'(PER2);
            default: return cnt_t'(PER3);
        endcase
    endfunction

    logic       wr_q, rd_q, nmi_q, txd_q;
    logic [7:0] rda_q, dout_q, txreg_q, rxreg_q;
    logic [4:0] sctrl_q;
    logic       txf_q, rxf_q, ferr_q;
    logic       txf_d, rxf_d, ferr_d;
    st_t        tx_st_q, rx_st_q;
    cnt_t       tx_cnt_q, rx_cnt_q;
    logic [2:0] tx_bit_q, rx_bit_q;
    logic [7:0] tx_sh_q, rx_sh_q;
    logic       rx_s1_q, rx_s2_q, rx_prev_q;

    logic       wr_pulse, rd_rise, wr03, wr05;
    logic       clr_rxf, clr_ferr;
    logic       ten, ren, nen;
    logic [1:0] baud;
    cnt_t       per, half;
    logic       tx_done, tx_abort, rx_done, rx_load;

    assign wr_pulse = wr_q & ~WR_n;
    assign rd_rise  = ~rd_q & RD_n;
    assign wr03     = wr_pulse && (A == 8'h03);
    assign wr05     = wr_pulse && (A == 8'h05);
    assign clr_rxf  = rd_rise && (rda_q == 8'h04);
    assign clr_ferr = rd_rise && (rda_q == 8'h05);
    assign baud     = sctrl_q[4:3];
    assign ren      = sctrl_q[2];
    assign ten      = sctrl_q[1];
    assign nen      = sctrl_q[0];
    assign per      = period(baud);
    assign half     = per >> 1;
    assign tx_done  = ten && tx_st_q == STOP && tx_cnt_q == '0;
    assign tx_abort = !ten && tx_st_q != IDLE;
    assign rx_done  = ren && rx_st_q == STOP && rx_cnt_q == '0;

    // Flag next-state: read-clears apply before completion; ferr set beats clear
    always_comb begin
        txf_d = txf_q;
        if (tx_done || tx_abort)
            txf_d = 1'b0;
        else if (wr03)
            txf_d = 1'b1;
        rxf_d   = rxf_q & ~clr_rxf;
        rx_load = rx_done && !rxf_d;
        if (rx_load)
            rxf_d = 1'b1;
        ferr_d = ferr_q & ~clr_ferr;
        if (rx_done && (!rx_s2_q || !rx_load))
            ferr_d = 1'b1;
    end

    // Bus strobes, register file, read mux, flags and NMI
    always_ff @(posedge clk) begin
        if (!RESET_n) begin
            wr_q    <= 1'b1;
            rd_q    <= 1'b1;
            rda_q   <= 8'h00;
            dout_q  <= 8'hFF;
            sctrl_q <= 5'b0;
            txreg_q <= 8'h00;
            rxreg_q <= 8'hFF;
            txf_q   <= 1'b0;
            rxf_q   <= 1'b0;
            ferr_q  <= 1'b0;
            nmi_q   <= 1'b1;
        end else begin
            wr_q <= WR_n;
            rd_q <= RD_n;
            if (!RD_n) begin
                rda_q <= A;
                case (A)
                    8'h03:   dout_q <= txreg_q;
                    8'h04:   dout_q <= rxreg_q;
                    8'h05:   dout_q <= {sctrl_q, ferr_q, rxf_q, txf_q};
                    default: dout_q <= 8'hFF;
                endcase
            end
            if (wr05)
                sctrl_q <= D_in[7:3];
            if (wr03 && !txf_q)
                txreg_q <= D_in;
            if (rx_load)
                rxreg_q <= rx_sh_q;
            txf_q  <= txf_d;
            rxf_q  <= rxf_d;
            ferr_q <= ferr_d;
            nmi_q  <= ~(nen & rxf_q);
        end
    end

    // TX FSM: start, 8 data bits LSB first, stop; one bit period per step
    always_ff @(posedge clk) begin
        if (!RESET_n) begin
            tx_st_q  <= IDLE;
            tx_cnt_q <= '0;
            tx_bit_q <= 3'd0;
            tx_sh_q  <= 8'h00;
            txd_q    <= 1'b1;
        end else if (tx_abort) begin
            tx_st_q <= IDLE;
            txd_q   <= 1'b1;
        end else if (tx_st_q == IDLE) begin
            if (txf_q && ten) begin
                tx_st_q  <= START;
                tx_sh_q  <= txreg_q;
                tx_cnt_q <= per - cnt_t'(1);
                txd_q    <= 1'b0;
            end
        end else if (tx_cnt_q != '0) begin
            tx_cnt_q <= tx_cnt_q - cnt_t'(1);
        end else begin
            tx_cnt_q <= per - cnt_t'(1);
            unique case (tx_st_q)
                START: begin
                    tx_st_q  <= DATA;
                    tx_bit_q <= 3'd0;
                    txd_q    <= tx_sh_q[0];
                    tx_sh_q  <= tx_sh_q >> 1;
                end
                DATA: begin
                    if (tx_bit_q == 3'd7) begin
                        tx_st_q <= STOP;
                        txd_q   <= 1'b1;
                    end else begin
                        tx_bit_q <= tx_bit_q + 3'd1;
                        txd_q    <= tx_sh_q[0];
                        tx_sh_q  <= tx_sh_q >> 1;
                    end
                end
                STOP:    tx_st_q <= IDLE;
                default: tx_st_q <= IDLE;
            endcase
        end
    end

    // RX synchroniser and FSM: half-bit start check, then centre sampling
    always_ff @(posedge clk) begin
        if (!RESET_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            rx_st_q   <= IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= 3'd0;
            rx_sh_q   <= 8'h00;
        end else begin
            rx_s1_q   <= rxd;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            if (!ren) begin
                rx_st_q <= IDLE;
            end else if (rx_st_q == IDLE) begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_st_q  <= START;
                    rx_cnt_q <= half - cnt_t'(1);
                end
            end else if (rx_cnt_q != '0) begin
                rx_cnt_q <= rx_cnt_q - cnt_t'(1);
            end else begin
                rx_cnt_q <= per - cnt_t'(1);
                unique case (rx_st_q)
                    START: begin
                        rx_bit_q <= 3'd0;
                        rx_st_q  <= rx_s2_q ? IDLE : DATA;
                    end
                    DATA: begin
                        rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                        rx_bit_q <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7)
                            rx_st_q <= STOP;
                    end
                    STOP:    rx_st_q <= IDLE;
                    default: rx_st_q <= IDLE;
                endcase
            end
        end
    end

    assign D_out = dout_q;
    assign txd   = txd_q;
    assign nmi_n = nmi_q;

endmodule

// File: tb/tb_gg_serial_ctrl.sv
// tb_gg_serial_ctrl: scenario bench for the EXT-port serial engine.
// CLK_FREQ=48000 so 4800 baud is 10 clk per bit.
module tb_gg_serial_ctrl;

    logic       clk = 1'b0;
    logic       RESET_n = 1'b0;
    logic       WR_n = 1'b1;
    logic       RD_n = 1'b1;
    logic [7:0] A = 8'h00;
    logic [7:0] D_in = 8'h00;
    logic [7:0] D_out;
    logic       txd;
    logic       rxd = 1'b1;
    logic       nmi_n;

    int errors = 0;
    int checks = 0;

    logic       tx_q[$];
    logic [7:0] rx_q[$];

    gg_serial_ctrl #(.CLK_FREQ(48000)) dut (
        .clk(clk), .RESET_n(RESET_n), .WR_n(WR_n), .RD_n(RD_n),
        .A(A), .D_in(D_in), .D_out(D_out), .txd(txd),
        .rxd(rxd), .nmi_n(nmi_n)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        A = a; D_in = d; WR_n = 1'b0;
        repeat (3) @(negedge clk);
        WR_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        A = a; RD_n = 1'b0;
        repeat (2) @(negedge clk);
        d = D_out;
        RD_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_reg(input string nm, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        checks++;
        if (d !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, d, exp);
        end
    endtask

    task automatic chk_rx(input string nm);
        logic [7:0] d, exp;
        bus_read(8'h04, d);
        exp = rx_q.pop_front();
        checks++;
        if (d !== exp) begin
            errors++;
            $display("FAIL %s: rxd byte %h required %h", nm, d, exp);
        end
    endtask

    task automatic chk_bit(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b", nm, got, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_q.push_back(b[i]);
        tx_q.push_back(1'b1);
    endtask

    task automatic wait_txd_low(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (txd === 1'b0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic tx_capture();
        bit   ok;
        logic exp;
        wait_txd_low(ok);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL tx_start_timeout: txd %b required 0", txd);
            tx_q.delete();
            return;
        end
        repeat (5) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            exp = tx_q.pop_front();
            checks++;
            if (txd !== exp) begin
                errors++;
                $display("FAIL tx_bit%0d: txd %b required %b", i, txd, exp);
            end
            if (i < 9) repeat (10) @(negedge clk);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb);
        @(negedge clk);
        rxd = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (10) @(negedge clk);
        end
        rxd = stopb;
        repeat (10) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        RESET_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_bit("reset_txd", txd, 1'b1);
        chk_bit("reset_nmi", nmi_n, 1'b1);
        checks++;
        if (D_out !== 8'hFF) begin
            errors++;
            $display("FAIL reset_dout: got %h required ff", D_out);
        end
        RESET_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_reg("reset_sctrl", 8'h05, 8'h00);
        chk_reg("reset_rxreg", 8'h04, 8'hFF);
        chk_reg("reset_txreg", 8'h03, 8'h00);
        chk_reg("unmapped", 8'h07, 8'hFF);
    endtask

    task automatic test_tx();
        bus_write(8'h05, 8'h10);
        push_tx(8'hA5);
        fork
            bus_write(8'h03, 8'hA5);
            tx_capture();
            begin
                repeat (40) @(negedge clk);
                chk_reg("tx_busy_status", 8'h05, 8'h11);
            end
        join
        repeat (10) @(negedge clk);
        chk_reg("tx_done_status", 8'h05, 8'h10);
        chk_reg("txreg_readback", 8'h03, 8'hA5);
    endtask

    task automatic test_rx();
        bus_write(8'h05, 8'h28);
        rx_q.push_back(8'h3C);
        send_rx(8'h3C, 1'b1);
        repeat (2) @(negedge clk);
        chk_bit("rx_nmi_low", nmi_n, 1'b0);
        chk_reg("rx_status", 8'h05, 8'h2A);
        chk_rx("rx_byte");
        chk_reg("rx_cleared_status", 8'h05, 8'h28);
        chk_bit("rx_nmi_high", nmi_n, 1'b1);
    endtask

    task automatic test_overrun();
        rx_q.push_back(8'h55);
        send_rx(8'h55, 1'b1);
        send_rx(8'h66, 1'b1);
        repeat (2) @(negedge clk);
        chk_reg("overrun_status", 8'h05, 8'h2E);
        chk_reg("overrun_ferr_clr", 8'h05, 8'h2A);
        chk_rx("overrun_kept");
        chk_reg("overrun_final", 8'h05, 8'h28);
    endtask

    task automatic test_framing();
        rx_q.push_back(8'hA7);
        send_rx(8'hA7, 1'b0);
        repeat (2) @(negedge clk);
        chk_reg("frame_status", 8'h05, 8'h2E);
        chk_rx("frame_byte");
        chk_reg("frame_cleared", 8'h05, 8'h28);
        @(negedge clk);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        chk_reg("glitch_status", 8'h05, 8'h28);
        chk_reg("glitch_rxreg", 8'h04, 8'hA7);
        chk_bit("glitch_nmi", nmi_n, 1'b1);
    endtask

    task automatic test_back_to_back();
        rx_q.push_back(8'h11);
        rx_q.push_back(8'h22);
        fork
            begin
                send_rx(8'h11, 1'b1);
                send_rx(8'h22, 1'b1);
            end
            begin
                repeat (104) @(negedge clk);
                chk_rx("b2b_first");
            end
        join
        repeat (2) @(negedge clk);
        chk_reg("b2b_status", 8'h05, 8'h2A);
        chk_rx("b2b_second");
    endtask

    task automatic test_tx_abort();
        bit ok;
        bus_write(8'h05, 8'h10);
        fork
            bus_write(8'h03, 8'hA5);
            wait_txd_low(ok);
        join
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort_start_timeout: txd %b required 0", txd);
        end
        repeat (44) @(negedge clk);
        chk_bit("abort_bit3_low", txd, 1'b0);
        bus_write(8'h05, 8'h00);
        chk_bit("abort_txd_high", txd, 1'b1);
        repeat (20) @(negedge clk);
        chk_bit("abort_txd_stays", txd, 1'b1);
        chk_reg("abort_status", 8'h05, 8'h00);
    endtask

    task automatic test_reset_mid();
        bus_write(8'h05, 8'h38);
        bus_write(8'h03, 8'h80);
        repeat (20) @(negedge clk);
        fork
            send_rx(8'h0F, 1'b1);
            begin
                repeat (40) @(negedge clk);
                chk_bit("pre_reset_txd", txd, 1'b0);
                RESET_n = 1'b0;
                @(negedge clk);
                chk_bit("midrst_txd", txd, 1'b1);
                chk_bit("midrst_nmi", nmi_n, 1'b1);
                checks++;
                if (D_out !== 8'hFF) begin
                    errors++;
                    $display("FAIL midrst_dout: got %h required ff", D_out);
                end
            end
        join
        RESET_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_reg("midrst_sctrl", 8'h05, 8'h00);
        chk_reg("midrst_rxreg", 8'h04, 8'hFF);
        chk_reg("midrst_txreg", 8'h03, 8'h00);
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx();
        test_overrun();
        test_framing();
        test_back_to_back();
        test_tx_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
